rca_seq_ctrl: RTL and testbench

Sequencer that performs a wide (4*NIBBLES-bit) unsigned addition by time-multiplexing one external 4-bit ripple carry adder. The adder has ports in0[3:0], in1[3:0], out[3:0] and cout, and no carry-in. The block walks the operands nibble by nibble, LSB first. It injects the inter-nibble carry with a second "+1" pass through the same adder, and reports the result with a start/busy/done handshake. It sits between a requester (CPU-side register or test FSM) and the shared adder instance.

---
 rtl/rca_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_rca_seq_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// Wide unsigned adder sequencer: time-multiplexes one external 4-bit carry-less adder,
// nibble by nibble LSB first, injecting inter-nibble carries with an extra "+1" pass.
module rca_seq_ctrl #(
   parameter int unsigned NIBBLES = 4,
   localparam int unsigned W = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic [3:0]   add_in0,
   output logic [3:0]   add_in1,
   input  logic [3:0]   add_out,
   input  logic         add_cout
);

   localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   typedef enum logic [1:0] {StIdle, StAdd, StFix, StDone} state_e;

   state_e state_q, state_d;

   logic [NIBBLES-1:0][3:0] a_q, a_d;
   logic [NIBBLES-1:0][3:0] b_q, b_d;
   logic [NIBBLES-1:0][3:0] sum_q, sum_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic                    c_q, c_d;
   logic                    t_q, t_d;
   logic                    cout_q, cout_d;
   logic                    last;

   assign last = (idx_q == LastIdx);
   assign sum  = sum_q;
   assign cout = cout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StAdd;
         StAdd: begin
            if (c_q)       state_d = StFix;
            else if (last) state_d = StDone;
         end
         StFix:   state_d = last ? StDone : StAdd;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      add_in0 = 4'd0;
      add_in1 = 4'd0;
      busy    = (state_q != StIdle);
      done    = (state_q == StDone);
      unique case (state_q)
         StAdd: begin
            add_in0 = a_q[idx_q];
            add_in1 = b_q[idx_q];
         end
         StFix: begin
            add_in0 = sum_q[idx_q];
            add_in1 = 4'd1;
         end
         default: ;
      endcase
   end

   // Datapath next-state; the adder result is consumed combinationally in the same cycle.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      sum_d  = sum_q;
      idx_d  = idx_q;
      c_d    = c_q;
      t_d    = t_q;
      cout_d = cout_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d   = a;
               b_d   = b;
               idx_d = '0;
               c_d   = 1'b0;
            end
         end
         StAdd: begin
            sum_d[idx_q] = add_out;
            t_d          = add_cout;
            // A pending carry defers the index step to the following +1 pass.
            if (!c_q) begin
               c_d = add_cout;
               if (last) cout_d = add_cout;
               else      idx_d  = idx_q + IdxW'(1);
            end
         end
         StFix: begin
            sum_d[idx_q] = add_out;
            c_d          = t_q | add_cout;
            if (last) cout_d = t_q | add_cout;
            else      idx_d  = idx_q + IdxW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         idx_q  <= '0;
         c_q    <= 1'b0;
         t_q    <= 1'b0;
         cout_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         sum_q  <= sum_d;
         idx_q  <= idx_d;
         c_q    <= c_d;
         t_q    <= t_d;
         cout_q <= cout_d;
      end
   end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: models the external adder, and predicts sum, carry, latency and the
// adder input trace from plain wide arithmetic.
module tb_rca_seq_ctrl;

   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout, add_cout;
   logic [W-1:0] sum;
   logic [3:0]   add_in0, add_in1, add_out;

   int n_checks = 0;
   int n_fail = 0;

   int           lat, busy_n, done_n;
   logic [W-1:0] sum_at_done;
   logic         cout_at_done;
   logic [3:0]   tr0[$], tr1[$], e0[$], e1[$];

   rca_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .add_in0  (add_in0),
      .add_in1  (add_in1),
      .add_out  (add_out),
      .add_cout (add_cout)
   );

   assign {add_cout, add_out} = {1'b0, add_in0} + {1'b0, add_in1};

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog");
   end

   // Reference model
   function automatic bit carry_in(input logic [W-1:0] av, input logic [W-1:0] bv, input int i);
      longint unsigned m = (64'd1 << (4 * i)) - 64'd1;
      longint unsigned x = 64'(av);
      longint unsigned y = 64'(bv);
      return (((x & m) + (y & m)) >> (4 * i)) != 64'd0;
   endfunction

   function automatic int exp_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
      int f = 0;
      for (int i = 1; i < int'(NIBBLES); i++) if (carry_in(av, bv, i)) f++;
      return int'(NIBBLES) + 1 + f;
   endfunction

   function automatic logic [W:0] exp_sum(input logic [W-1:0] av, input logic [W-1:0] bv);
      longint unsigned s = 64'(av) + 64'(bv);
      return (W + 1)'(s);
   endfunction

   task automatic build_trace(input logic [W-1:0] av, input logic [W-1:0] bv);
      e0.delete();
      e1.delete();
      for (int i = 0; i < int'(NIBBLES); i++) begin
         logic [3:0] an = 4'((av >> (4 * i)) & 16'hF);
         logic [3:0] bn = 4'((bv >> (4 * i)) & 16'hF);
         e0.push_back(an);
         e1.push_back(bn);
         if (i >= 1 && carry_in(av, bv, i)) begin
            e0.push_back(an + bn);
            e1.push_back(4'd1);
         end
      end
   endtask

   function automatic int trace_errs();
      int e = 0;
      if (tr0.size() != e0.size()) return 1000 + tr0.size();
      foreach (tr0[j]) if (tr0[j] !== e0[j] || tr1[j] !== e1[j]) e++;
      return e;
   endfunction

   // Runs one operation; glitch_k != 0 pulses start with new operands in that busy cycle and
   // in the DONE cycle. Ends at the negedge of the cycle after DONE.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit immediate,
                        input int glitch_k);
      if (!immediate) @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      lat = 0;
      busy_n = 0;
      done_n = 0;
      tr0.delete();
      tr1.delete();
      for (int k = 1; k <= 40; k++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (lat == 0) begin
               lat = k;
               sum_at_done = sum;
               cout_at_done = cout;
            end
         end else if (busy) begin
            tr0.push_back(add_in0);
            tr1.push_back(add_in1);
         end
         if (lat != 0 && k == lat + 1) break;
         start = (glitch_k != 0) && (k == glitch_k || done);
         if (start) begin
            a = '1;
            b = '1;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if ({busy, done, cout, sum, add_in0, add_in1} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h in0=%h in1=%h, want all 0",
                  busy, done, cout, sum, add_in0, add_in1);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_zero();
      logic [W:0] s = exp_sum('0, '0);
      do_op('0, '0, 1'b0, 0);
      build_trace('0, '0);
      n_checks++;
      if ({cout_at_done, sum_at_done} !== s || lat != 5 || trace_errs() != 0) begin
         n_fail++;
         $display("FAIL zero_add: got sum=%h cout=%b lat=%0d trace_errs=%0d, want sum=%h cout=%b lat=5",
                  sum_at_done, cout_at_done, lat, trace_errs(), s[W-1:0], s[W]);
      end
   endtask

   task automatic test_pattern();
      logic [W:0] s = exp_sum(16'h1234, 16'h4321);
      do_op(16'h1234, 16'h4321, 1'b0, 0);
      build_trace(16'h1234, 16'h4321);
      n_checks++;
      if ({cout_at_done, sum_at_done} !== s) begin
         n_fail++;
         $display("FAIL pattern_sum: got %b_%h, want %b_%h", cout_at_done, sum_at_done, s[W], s[W-1:0]);
      end
      n_checks++;
      if (lat != exp_lat(16'h1234, 16'h4321) || busy_n != lat || done_n != 1) begin
         n_fail++;
         $display("FAIL pattern_timing: got lat=%0d busy=%0d done=%0d, want lat=%0d busy=lat done=1",
                  lat, busy_n, done_n, exp_lat(16'h1234, 16'h4321));
      end
      n_checks++;
      if (trace_errs() != 0) begin
         n_fail++;
         $display("FAIL pattern_trace: got %0d mismatching adder inputs (%0d entries), want 0 (%0d)",
                  trace_errs(), tr0.size(), e0.size());
      end
   endtask

   task automatic test_carry_chain();
      logic [W:0] s = exp_sum(16'hFFFF, 16'h0001);
      do_op(16'hFFFF, 16'h0001, 1'b0, 0);
      build_trace(16'hFFFF, 16'h0001);
      n_checks++;
      if ({cout_at_done, sum_at_done} !== s) begin
         n_fail++;
         $display("FAIL chain_sum: got %b_%h, want %b_%h", cout_at_done, sum_at_done, s[W], s[W-1:0]);
      end
      n_checks++;
      if (lat != 8 || busy_n != 8 || done_n != 1) begin
         n_fail++;
         $display("FAIL chain_timing: got lat=%0d busy=%0d done=%0d, want 8 8 1", lat, busy_n, done_n);
      end
      n_checks++;
      if (trace_errs() != 0) begin
         n_fail++;
         $display("FAIL chain_trace: got %0d mismatches, want 0", trace_errs());
      end
   endtask

   task automatic test_back_to_back();
      logic [W:0] s1 = exp_sum(16'h8000, 16'h8000);
      logic [W:0] s2 = exp_sum(16'h00FF, 16'h0001);
      do_op(16'h8000, 16'h8000, 1'b0, 0);
      n_checks++;
      if ({cout_at_done, sum_at_done} !== s1 || lat != exp_lat(16'h8000, 16'h8000)) begin
         n_fail++;
         $display("FAIL b2b_first: got %b_%h lat=%0d, want %b_%h lat=%0d", cout_at_done, sum_at_done,
                  lat, s1[W], s1[W-1:0], exp_lat(16'h8000, 16'h8000));
      end
      do_op(16'h00FF, 16'h0001, 1'b1, 0);
      n_checks++;
      if ({cout_at_done, sum_at_done} !== s2 || lat != exp_lat(16'h00FF, 16'h0001) || done_n != 1) begin
         n_fail++;
         $display("FAIL b2b_second: got %b_%h lat=%0d done=%0d, want %b_%h lat=%0d done=1",
                  cout_at_done, sum_at_done, lat, done_n, s2[W], s2[W-1:0],
                  exp_lat(16'h00FF, 16'h0001));
      end
   endtask

   task automatic test_ignore_start();
      logic [W:0] s = exp_sum(16'h0F0F, 16'h0101);
      do_op(16'h0F0F, 16'h0101, 1'b0, 2);
      n_checks++;
      if ({cout_at_done, sum_at_done} !== s || lat != exp_lat(16'h0F0F, 16'h0101) || done_n != 1) begin
         n_fail++;
         $display("FAIL ignore_start: got %b_%h lat=%0d done=%0d, want %b_%h lat=%0d done=1",
                  cout_at_done, sum_at_done, lat, done_n, s[W], s[W-1:0],
                  exp_lat(16'h0F0F, 16'h0101));
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || sum !== s[W-1:0] || cout !== s[W]) begin
         n_fail++;
         $display("FAIL ignore_idle: got busy=%b sum=%h cout=%b, want busy=0 sum=%h cout=%b",
                  busy, sum, cout, s[W-1:0], s[W]);
      end
   endtask

   task automatic test_reset_midop();
      logic [W:0] s = exp_sum(16'hFFFF, 16'hFFFF);
      int seen_done = 0;
      @(negedge clk);
      a = 16'h1234;
      b = 16'h4321;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (add_in0 !== 4'h2 || add_in1 !== 4'h3) begin
         n_fail++;
         $display("FAIL midop_nibble2: got in0=%h in1=%h, want 2 3", add_in0, add_in1);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, cout, sum, add_in0, add_in1} !== '0) begin
         n_fail++;
         $display("FAIL midop_reset: got busy=%b done=%b cout=%b sum=%h in0=%h in1=%h, want all 0",
                  busy, done, cout, sum, add_in0, add_in1);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      n_checks++;
      if (seen_done != 0) begin
         n_fail++;
         $display("FAIL midop_no_done: got %0d done/busy cycles after reset, want 0", seen_done);
      end
      do_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
      n_checks++;
      if ({cout_at_done, sum_at_done} !== s || lat != 8 || done_n != 1) begin
         n_fail++;
         $display("FAIL after_reset_op: got %b_%h lat=%0d done=%0d, want %b_%h lat=8 done=1",
                  cout_at_done, sum_at_done, lat, done_n, s[W], s[W-1:0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         logic [W-1:0] av = W'($urandom);
         logic [W-1:0] bv = W'($urandom);
         logic [W:0]   s;
         if (n % 4 == 0) av = ~bv ^ W'($urandom_range(0, 3));
         s = exp_sum(av, bv);
         build_trace(av, bv);
         do_op(av, bv, n % 3 == 0, (n % 5 == 1) ? 1 : 0);
         n_checks++;
         if ({cout_at_done, sum_at_done} !== s || lat != exp_lat(av, bv) || busy_n != lat ||
             done_n != 1 || trace_errs() != 0) begin
            n_fail++;
            $display("FAIL random_%0d: a=%h b=%h got %b_%h lat=%0d busy=%0d done=%0d trace_errs=%0d, want %b_%h lat=%0d",
                     n, av, bv, cout_at_done, sum_at_done, lat, busy_n, done_n, trace_errs(),
                     s[W], s[W-1:0], exp_lat(av, bv));
         end
         if (n % 3 == 2) begin
            repeat (2) begin
               a = W'($urandom);
               b = W'($urandom);
               @(negedge clk);
            end
            n_checks++;
            if (sum !== s[W-1:0] || cout !== s[W] || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL random_hold_%0d: got sum=%h cout=%b busy=%b, want %h %b 0",
                        n, sum, cout, busy, s[W-1:0], s[W]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_pattern();
      test_carry_chain();
      test_back_to_back();
      test_ignore_start();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
